// File: rtl/rv32i_sequencer.sv
// rv32i_sequencer
//   Multi-cycle control sequencer for a small RV32I core. Walks every
//   instruction through FETCH -> EXEC -> (MEM -> (WB)) over one shared memory
//   port and emits one-cycle enables and selects for the datapath. Only the
//   opcode and the SYSTEM encodings are decoded; the datapath does the maths.
//
//   Parameters
//     INIT_CYCLES   cycles spent in INIT after reset release (1..15)
//
//   Ports
//     CLK           core clock
//     RESET         asynchronous, active-high reset
//     instr[31:0]   instruction register contents from the datapath
//     mem_ack       memory handshake (may be combinational from mem_req)
//     mem_req       memory access request
//     mem_addr_sel  0 = PC address, 1 = ALU (load/store) address
//     mem_we        store strobe, valid only while mem_req = 1
//     ir_we         instruction register load pulse
//     pc_we         PC update pulse
//     rf_we         register file write pulse
//     halted        core stopped
//     trap          stopped because of an illegal instruction
//     state[2:0]    current FSM state (debug)
//     instret[31:0] retired-instruction counter (only with RETIRE_COUNT_EN)
//
//   Optional feature macro: RETIRE_COUNT_EN
//     Defined   -> adds the instret output, counting every pc_we pulse.
//     Undefined -> no instret port or counter.

module rv32i_sequencer #(
    parameter int unsigned INIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] instr,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        halted,
    output logic        trap,
    output logic [2:0]  state
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    localparam logic [6:0]  OP_OP     = 7'b0110011;
    localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_FENCE  = 7'b0001111;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] I_ECALL   = 32'h0000_0073;
    localparam logic [31:0] I_EBREAK  = 32'h0010_0073;

    localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_sel_q, mem_sel_d;
    logic       mem_we_q, mem_we_d;
    logic       halted_q, halted_d;
    logic       trap_q, trap_d;

    // Instruction classes
    logic       is_wr_pc;    // writes rd and advances PC
    logic       is_pc_only;  // advances PC, no register write
    logic       is_mem;      // load or store
    logic       is_store;
    logic       is_ebreak;
    logic       rd_nz;

    always_comb begin
        is_wr_pc   = 1'b0;
        is_pc_only = 1'b0;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_ebreak  = 1'b0;
        rd_nz      = |instr[11:7];
        case (instr[6:0])
            OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                is_wr_pc = 1'b1;
            OP_BRANCH, OP_FENCE:
                is_pc_only = 1'b1;
            OP_LOAD:
                is_mem = 1'b1;
            OP_STORE: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_SYSTEM: begin
                // ECALL is retired as a NOP; EBREAK halts cleanly.
                is_pc_only = (instr == I_ECALL);
                is_ebreak  = (instr == I_EBREAK);
            end
            default: ;
        endcase
    end

    // Next state and the one-cycle pulses. The pulses stay combinational so
    // that ir_we / pc_we land in the same cycle as a combinational mem_ack,
    // which is what gives the 2/3/4-cycle zero-wait latencies.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        rf_we   = 1'b0;
        case (state_q)
            S_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_wr_pc) begin
                    rf_we   = rd_nz;
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else if (is_pc_only) begin
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (mem_we_q) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = rd_nz;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: ;
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Level outputs are registered from the state being entered.
    always_comb begin
        mem_req_d = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_sel_d = (state_d == S_MEM);
        mem_we_d  = (state_d == S_MEM) &&
                    ((state_q == S_MEM) ? mem_we_q : is_store);
        halted_d  = (state_d == S_HALT);
        // trap is set only on an EXEC->HALT that is not EBREAK, then held.
        trap_d    = ((state_q == S_EXEC) && (state_d == S_HALT) && !is_ebreak) ||
                    ((state_q == S_HALT) && trap_q);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            mem_sel_q <= 1'b0;
            mem_we_q  <= 1'b0;
            halted_q  <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_req_q <= mem_req_d;
            mem_sel_q <= mem_sel_d;
            mem_we_q  <= mem_we_d;
            halted_q  <= halted_d;
            trap_q    <= trap_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr_sel = mem_sel_q;
    assign mem_we       = mem_we_q;
    assign halted       = halted_q;
    assign trap         = trap_q;
    assign state        = state_q;

`ifdef RETIRE_COUNT_EN
    logic [31:0] instret_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            instret_q <= '0;
        end else if (pc_we) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_rv32i_sequencer.sv
module tb_rv32i_sequencer;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;

    // Expected-flag bits: {req, sel, we, ir_we, pc_we, rf_we, halted, trap}
    localparam logic [7:0] F_REQ = 8'h80;
    localparam logic [7:0] F_SEL = 8'h40;
    localparam logic [7:0] F_WE  = 8'h20;
    localparam logic [7:0] F_IRW = 8'h10;
    localparam logic [7:0] F_PCW = 8'h08;
    localparam logic [7:0] F_RFW = 8'h04;
    localparam logic [7:0] F_HLT = 8'h02;
    localparam logic [7:0] F_TRP = 8'h01;

    localparam logic [31:0] I_ADD   = 32'h0000_00B3;
    localparam logic [31:0] I_ADDI  = 32'h0010_8093;
    localparam logic [31:0] I_SW    = 32'h0011_2023;
    localparam logic [31:0] I_LW3   = 32'h0001_2183;
    localparam logic [31:0] I_LW0   = 32'h0001_2003;
    localparam logic [31:0] I_EBRK  = 32'h0010_0073;
    localparam logic [31:0] I_ILL   = 32'h0000_007F;

    logic        CLK;
    logic        RESET;
    logic [31:0] instr;
    logic        mem_ack;
    logic        mem_req, mem_addr_sel, mem_we, ir_we, pc_we, rf_we, halted, trap;
    logic [2:0]  state;
`ifdef RETIRE_COUNT_EN
    logic [31:0] instret;
    logic [31:0] exp_ret;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] f;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks;
    int unsigned errors;
    logic [31:0] ir;

    rv32i_sequencer #(.INIT_CYCLES(1)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .instr        (instr),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_addr_sel (mem_addr_sel),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .halted       (halted),
        .trap         (trap),
        .state        (state)
`ifdef RETIRE_COUNT_EN
        ,
        .instret      (instret)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] st, input logic [7:0] f);
        exp_t e;
        e.st = st;
        e.f  = f;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard: observed empty expected entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".state"},   32'(state),        32'(e.st));
        chk({tag, ".mem_req"}, 32'(mem_req),      32'(e.f[7]));
        chk({tag, ".sel"},     32'(mem_addr_sel), 32'(e.f[6]));
        chk({tag, ".mem_we"},  32'(mem_we),       32'(e.f[5]));
        chk({tag, ".ir_we"},   32'(ir_we),        32'(e.f[4]));
        chk({tag, ".pc_we"},   32'(pc_we),        32'(e.f[3]));
        chk({tag, ".rf_we"},   32'(rf_we),        32'(e.f[2]));
        chk({tag, ".halted"},  32'(halted),       32'(e.f[1]));
        chk({tag, ".trap"},    32'(trap),         32'(e.f[0]));
`ifdef RETIRE_COUNT_EN
        chk({tag, ".instret"}, instret, exp_ret);
        if (e.f[3]) exp_ret = exp_ret + 32'd1;
`endif
    endtask

    // One clock cycle: drive inputs just after the edge, sample at negedge.
    task automatic cyc(input string tag, input logic r, input logic ack,
                       input logic [2:0] st, input logic [7:0] f);
        @(posedge CLK);
        #1;
        RESET   = r;
        instr   = ir;
        mem_ack = ack;
`ifdef RETIRE_COUNT_EN
        if (r) exp_ret = '0;
`endif
        push_exp(st, f);
        @(negedge CLK);
        check_out(tag);
    endtask

    task automatic fetch(input int unsigned waits);
        for (int unsigned w = 0; w < waits; w++) cyc("fetch_wait", 1'b0, 1'b0, ST_FETCH, F_REQ);
        cyc("fetch", 1'b0, 1'b1, ST_FETCH, F_REQ | F_IRW);
    endtask

    task automatic exec(input string tag, input logic [31:0] iv, input logic [7:0] f);
        ir = iv;
        cyc(tag, 1'b0, 1'b1, ST_EXEC, f);
    endtask

    task automatic do_reset();
        cyc("reset", 1'b1, 1'b1, ST_INIT, 8'h00);
        cyc("init", 1'b0, 1'b1, ST_INIT, 8'h00);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        ir      = '0;
        RESET   = 1'b0;
        instr   = '0;
        mem_ack = 1'b1;
`ifdef RETIRE_COUNT_EN
        exp_ret = '0;
`endif
        #1 RESET = 1'b1;

        // Reset with ack tied high, then one INIT cycle
        cyc("reset", 1'b1, 1'b1, ST_INIT, 8'h00);
        cyc("reset", 1'b1, 1'b1, ST_INIT, 8'h00);
        cyc("init",  1'b0, 1'b1, ST_INIT, 8'h00);

        // Zero-wait ALU run: ADD x1 then 4x ADDI x1
        fetch(0);
        exec("add", I_ADD, F_PCW | F_RFW);
        for (int unsigned k = 0; k < 4; k++) begin
            fetch(0);
            exec("addi", I_ADDI, F_PCW | F_RFW);
        end

        // Fetch wait states, branch, ECALL, JAL x0, FENCE
        fetch(2);
        exec("beq", 32'h0000_0063, F_PCW);
        fetch(0);
        exec("ecall", 32'h0000_0073, F_PCW);
        fetch(0);
        exec("jal_x0", 32'h0000_006F, F_PCW);
        fetch(0);
        exec("fence", 32'h0000_000F, F_PCW);

        // Store, ack delayed 3 cycles
        fetch(0);
        exec("sw", I_SW, 8'h00);
        for (int unsigned k = 0; k < 3; k++) cyc("sw_wait", 1'b0, 1'b0, ST_MEM, F_REQ | F_SEL | F_WE);
        cyc("sw_ack", 1'b0, 1'b1, ST_MEM, F_REQ | F_SEL | F_WE | F_PCW);

        // Load x3 zero-wait
        fetch(0);
        exec("lw3", I_LW3, 8'h00);
        cyc("lw3_mem", 1'b0, 1'b1, ST_MEM, F_REQ | F_SEL);
        cyc("lw3_wb",  1'b0, 1'b1, ST_WB,  F_PCW | F_RFW);

        // Load x0 with one wait
        fetch(0);
        exec("lw0", I_LW0, 8'h00);
        cyc("lw0_wait", 1'b0, 1'b0, ST_MEM, F_REQ | F_SEL);
        cyc("lw0_mem",  1'b0, 1'b1, ST_MEM, F_REQ | F_SEL);
        cyc("lw0_wb",   1'b0, 1'b1, ST_WB,  F_PCW);

        // EBREAK: clean halt, no requests for 20 cycles
        fetch(0);
        exec("ebreak", I_EBRK, 8'h00);
        for (int unsigned k = 0; k < 20; k++) cyc("halt_ebrk", 1'b0, 1'b1, ST_HALT, F_HLT);

        // Illegal opcode
        do_reset();
        fetch(0);
        exec("illegal", I_ILL, 8'h00);
        for (int unsigned k = 0; k < 5; k++) cyc("halt_ill", 1'b0, 1'b1, ST_HALT, F_HLT | F_TRP);

        // Illegal SYSTEM encoding (MRET)
        do_reset();
        fetch(0);
        exec("mret", 32'h3020_0073, 8'h00);
        for (int unsigned k = 0; k < 3; k++) cyc("halt_sys", 1'b0, 1'b1, ST_HALT, F_HLT | F_TRP);

        // Second EBREAK after reset: trap must be clear again
        do_reset();
        fetch(0);
        exec("ebreak2", I_EBRK, 8'h00);
        for (int unsigned k = 0; k < 5; k++) cyc("halt_ebrk2", 1'b0, 1'b1, ST_HALT, F_HLT);

        // Reset during a held load request
        do_reset();
        fetch(0);
        exec("lw_rst", I_LW3, 8'h00);
        cyc("lw_hold", 1'b0, 1'b0, ST_MEM, F_REQ | F_SEL);
        cyc("lw_hold", 1'b0, 1'b0, ST_MEM, F_REQ | F_SEL);
        #2 RESET = 1'b1;
`ifdef RETIRE_COUNT_EN
        exp_ret = '0;
`endif
        push_exp(ST_INIT, 8'h00);
        #1 check_out("async_rst");
        cyc("late_ack", 1'b1, 1'b1, ST_INIT, 8'h00);
        cyc("init",     1'b0, 1'b1, ST_INIT, 8'h00);
        fetch(0);
        exec("addi_post", I_ADDI, F_PCW | F_RFW);
        fetch(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_sequencer.md
Name: rv32i_sequencer

Overview:
Multi-cycle control FSM for the RV32I core inside SOC. It sequences fetch, execute, memory access and write-back over a single shared memory port. Its outputs are one-cycle enables and selects for the datapath: PC, instruction register, register file and memory address mux. It decodes only the opcode and SYSTEM encodings; the datapath does all arithmetic.

Parameters:
INIT_CYCLES, 1, number of cycles spent in INIT after reset release before the first FETCH (range 1..15).

Ports:
CLK  in  1  core clock (divided clock in SOC)
RESET  in  1  asynchronous, active-high reset
instr  in  32  current instruction register contents from datapath
mem_ack  in  1  memory handshake; may be combinational from mem_req
mem_req  out  1  memory access request
mem_addr_sel  out  1  0 = PC address, 1 = ALU (load/store) address
mem_we  out  1  store strobe, valid only while mem_req=1
ir_we  out  1  instruction register load pulse
pc_we  out  1  PC update pulse; datapath picks next-PC source
rf_we  out  1  register file write pulse
halted  out  1  core stopped
trap  out  1  stopped because of an illegal instruction
state  out  3  current FSM state, for debug

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high. RESET forces state to INIT, clears the INIT counter and drives every output to 0 immediately, including mid-transaction. An in-flight mem_req drops at once and its ack is ignored.
- State encoding: INIT=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 return to INIT on the next edge.
- INIT: all outputs 0. Stay INIT_CYCLES cycles, then go to FETCH.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - Hold mem_req until mem_ack is sampled high.
  - On the ack cycle: ir_we=1 for exactly that cycle; next state EXEC.
- EXEC: decode instr[6:0].
  - ALU ops (0110011, 0010011, 0110111, 0010111) and jumps (1101111, 1100111): rf_we=1 if instr[11:7]!=0; pc_we=1; next state FETCH.
  - Branch 1100011 and FENCE 0001111: pc_we=1, rf_we=0; next state FETCH.
  - Load 0000011 or store 0100011: no pulses; next state MEM.
  - SYSTEM 1110011:
    - 0x00000073 (ECALL) behaves as a NOP: pc_we=1.
    - 0x00100073 (EBREAK): next state HALT with trap=0, no pc_we.
    - Any other SYSTEM encoding is illegal.
  - Any other opcode is illegal: next state HALT, trap=1, no pulses.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for stores only.
  - On mem_ack: load goes to WB; store pulses pc_we on the ack cycle and goes to FETCH.
- WB: rf_we=1 if rd!=0; pc_we=1; next state FETCH.
- HALT: halted=1 and trap stays latched. mem_req, ir_we, pc_we and rf_we are 0. Only RESET exits.
- Latency with zero-wait memory (ack in the same cycle as req): ALU/branch/jump 2 cycles, store 3, load 4. Each wait cycle adds one.
- mem_ack outside FETCH/MEM, or while mem_req=0, is ignored.
- Per state, at most one of ir_we, pc_we, rf_we-with-pc_we-pairing occurs. ir_we never coincides with pc_we or rf_we.

Optional Feature:
RETIRE_COUNT_EN
- Defined:
  - Adds output instret (32 bits), reset to 0.
  - Increments on every pc_we pulse and wraps 0xFFFFFFFF to 0.
  - EBREAK and illegal instructions do not count.
- Undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Reset timing: RESET=1 then release, INIT_CYCLES=1, mem_ack tied high. Required: state 0 for 1 cycle, then 1; mem_req high from cycle 2; all pulses 0 during RESET.
- Zero-wait ALU sequence: instr sequence 0x000000B3 (ADD x1,x0,x0), then 0x00108093 (ADDI x1,x1,1) four times, mem_ack tied high. Required: each instruction takes exactly 2 cycles; rf_we and pc_we both pulse in EXEC; 5 rf_we pulses total (instret=5 with the macro).
- Store with wait states: instr 0x00112023 (SW x1,0(x2)), ack delayed 3 cycles in MEM. Required: mem_req=1, mem_addr_sel=1, mem_we=1 held 4 cycles; pc_we on the ack cycle only; rf_we never asserted.
- Load and x0 write: LW x3,0(x2) (0x00012183) gives FETCH→EXEC→MEM→WB with rf_we in WB. LW x0 (0x00012003) completes the same sequence with rf_we=0.
- Halt cases: 0x00100073 gives halted=1, trap=0, mem_req stays 0 for 20 cycles. Opcode 0x0000007F gives halted=1, trap=1. A second EBREAK after reset repeats the result.
- Reset mid-operation: assert RESET in MEM during a held load request. Required: mem_req falls in the same cycle, without waiting for a clock edge; the late mem_ack is ignored; after release the core restarts at INIT then FETCH.
